// File: rtl/operand_buffer_pkg.sv
// Shared types and defaults for the operand buffer slice.
package operand_buffer_pkg;
  typedef enum logic {LOAD = 1'b0, STREAM = 1'b1} operand_buffer_state_t;

  localparam int BRAM_DEPTH_DEF = 2;
  localparam int DATA_WIDTH_DEF = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/operand_buffer_if.sv
// Load port, control_unit address stream and compute-side output of the operand buffer.
interface operand_buffer_if
  import operand_buffer_pkg::*;
#(
  parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  reload;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  loaded;
  logic                  enable_cu;
  logic                  write_mode;
  logic [BRAM_DEPTH-1:0] address;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  overflow_err;
  logic                  underrun_err;

  modport master (
    output reload, load_valid, load_data, enable_cu, write_mode, address, out_ready,
    input  load_ready, loaded, out_valid, out_data, overflow_err, underrun_err
  );

  modport slave (
    input  reload, load_valid, load_data, enable_cu, write_mode, address, out_ready,
    output load_ready, loaded, out_valid, out_data, overflow_err, underrun_err
  );
endinterface

// File: rtl/operand_fifo.sv
// Small synchronous FIFO; head reads as zero while empty.
module operand_fifo
  import operand_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic [DATA_WIDTH-1:0]       head
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] store;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);
  assign head    = (count != '0) ? store[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/operand_buffer.sv
// Operand store fed by control_unit addresses; registered BRAM read into a credit-checked output FIFO.
module operand_buffer
  import operand_buffer_pkg::*;
#(
  parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  operand_buffer_if.slave bus
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [0:0] S_LOAD   = LOAD;
  localparam logic [0:0] S_STREAM = STREAM;
  localparam logic [CW:0] CREDIT_LIM = (CW+1)'(FIFO_DEPTH);

  logic [0:0]            state;
  logic [BRAM_DEPTH-1:0] load_ptr;
  logic [DATA_WIDTH-1:0] mem [2**BRAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit;
  logic                  out_valid, pop, rd_strobe, rd_accept, load_fire;
  logic                  ovf_err, und_err;

  assign bus.load_ready   = (state == S_LOAD);
  assign bus.loaded       = (state == S_STREAM);
  assign bus.out_valid    = out_valid;
  assign bus.overflow_err = ovf_err;
  assign bus.underrun_err = und_err;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & bus.out_ready;
  assign load_fire = bus.load_valid & (state == S_LOAD) & ~bus.reload;
  assign rd_strobe = bus.enable_cu & ~bus.write_mode;

  // The sequencer never stalls, so a read is only taken if the word it lands
  // as can still fit once everything already owed to the FIFO has arrived.
  assign credit    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign rd_accept = (state == S_STREAM) & rd_strobe & ~bus.reload & (credit < CREDIT_LIM);

  always_ff @(posedge clk) begin
    if (reset || bus.reload) begin
      state    <= S_LOAD;
      load_ptr <= '0;
      inflight <= 1'b0;
      ovf_err  <= 1'b0;
      und_err  <= 1'b0;
    end else begin
      inflight <= rd_accept;
      if (load_fire) begin
        load_ptr <= load_ptr + 1'b1;
        if (load_ptr == '1) state <= S_STREAM;
      end
      if ((state == S_LOAD) && rd_strobe)                 und_err <= 1'b1;
      if ((state == S_STREAM) && rd_strobe && !rd_accept) ovf_err <= 1'b1;
    end
  end

  // Memory contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (load_fire) mem[load_ptr] <= bus.load_data;
    if (rd_accept) rd_data <= mem[bus.address];
  end

  operand_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.reload),
    .push     (inflight),
    .push_data(rd_data),
    .pop      (pop),
    .count    (fifo_count),
    .head     (bus.out_data)
  );
endmodule

// File: doc/operand_buffer.md
Name: operand_buffer

Overview:
- BRAM-style operand store that sits directly downstream of control_unit.
- Consumes control_unit's enable_cu / write_mode / address stream and returns the addressed words to the compute stage over a valid/ready output.
- Filled beforehand through a simple valid/ready load port.
- Absorbs compute-side backpressure with a small output FIFO, because the address sequencer never stalls.

Parameters:
- BRAM_DEPTH, 2, address width in bits; memory holds 2**BRAM_DEPTH words.
- DATA_WIDTH, 32, operand word width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- reload  in  1  pulse: flush everything and return to LOAD.
- load_valid  in  1  load word present.
- load_data  in  DATA_WIDTH  load word.
- load_ready  out  1  block accepts load word this cycle.
- loaded  out  1  all 2**BRAM_DEPTH words written.
- enable_cu  in  1  read/write strobe from control_unit.
- write_mode  in  1  0 = read, 1 = write (write strobes are ignored here).
- address  in  BRAM_DEPTH  word address from control_unit.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_WIDTH  operand to compute stage.
- out_ready  in  1  compute stage accepts.
- overflow_err  out  1  sticky: read dropped because FIFO credit was exhausted.
- underrun_err  out  1  sticky: read strobe received while not loaded.

Behaviour:
- Reset (synchronous, active-high):
  - state = LOAD, load pointer = 0, FIFO empty, in-flight flag = 0.
  - load_ready = 1, loaded = 0, out_valid = 0, out_data = 0, both error flags = 0.
  - Memory contents are not cleared.
- FSM states: LOAD, STREAM.
- LOAD:
  - load_ready = 1.
  - On load_valid & load_ready: mem[load_ptr] <= load_data; load_ptr++.
  - The write of word 2**BRAM_DEPTH-1 moves the FSM to STREAM next cycle; loaded = 1 and load_ready = 0 from that cycle on.
  - Read strobes (enable_cu & !write_mode) are ignored and set underrun_err.
- STREAM:
  - Read strobe = enable_cu & !write_mode.
  - Strobes with write_mode = 1 are ignored, no error.
  - An accepted read registers mem[address]; the word is pushed into the FIFO one cycle later (in-flight for exactly 1 cycle).
  - address wraps naturally mod 2**BRAM_DEPTH; no range check.
- Credit rule: a read is accepted iff (fifo_count + inflight - pop_this_cycle) < FIFO_DEPTH, where pop = out_valid & out_ready.
  - Otherwise the read is dropped and overflow_err is set (sticky until reset/reload).
- Output and latency:
  - out_valid = FIFO non-empty; out_data = FIFO head (registered, no combinational path from address).
  - Latency: strobe at cycle N gives out_valid at N+2 when the FIFO was empty.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - out_data holds stable while out_valid & !out_ready.
- reload (either state, highest priority after reset):
  - Next cycle: state = LOAD, load_ptr = 0, FIFO flushed, in-flight read discarded, out_valid = 0, loaded = 0, errors cleared.
  - A load word offered in the same cycle is not written.
- Simultaneous load_valid in STREAM: ignored, because load_ready = 0.

Decomposition:
- Shared package holds:
  - operand_buffer_state_t enum {LOAD, STREAM}.
  - Default constants BRAM_DEPTH_DEF = 2, DATA_WIDTH_DEF = 32.
- One sub-module, operand_fifo:
  - Synchronous FIFO with push, pop, flush, count, head, parameterized by DATA_WIDTH/FIFO_DEPTH.
  - count is $clog2(FIFO_DEPTH)+1 bits wide.
- Memory is an inferred array in the top level with registered read.

Test Plan:
- Load 0xA0,0xA1,0xA2,0xA3 back-to-back, then read strobes at addresses 0..3 with out_ready = 1 -> loaded rises on the cycle after the 4th write; out_data = A0..A3, first out_valid 2 cycles after the first strobe; no errors.
- Load with load_valid toggling every other cycle -> exactly 4 writes, loaded asserts after the 4th accepted word, load_ready = 0 afterward.
- Hold out_ready = 0 and issue 6 consecutive read strobes -> first 4 accepted, strobes 5–6 dropped, overflow_err = 1, FIFO holds words for addresses 0..3.
- FIFO full, then out_ready = 1 and a strobe in the same cycle -> read accepted (pop credit), no overflow, order preserved.
- Read strobe at reset exit before loading -> underrun_err = 1, out_valid stays 0.
- reload asserted with 2 words in the FIFO and 1 in flight -> next cycle out_valid = 0, loaded = 0, state LOAD, in-flight word never appears.
